otp_ctrl_part_chk_resp: RTL and testbench
=========================================

OTP_CTRL_PART_CHK_RESP -- requirements
Module: otp_ctrl_part_chk_resp

Interface
REQ-001 SHALL have parameter NumWords, default 8, number of partition words checked per request (>=2).
REQ-002 SHALL have parameter WordWidth, default 32, bit width of each word and of the digest.
REQ-003 SHALL have port clk_i, input, 1, sole clock.
REQ-004 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports integ_chk_req_i / cnsty_chk_req_i, input, 1, level check requests; each is held until acked.
REQ-006 SHALL have ports integ_chk_ack_o / cnsty_chk_ack_o, output, 1, single-cycle completion pulses.
REQ-007 SHALL have ports buf_addr_o, output, clog2(NumWords), and buf_rdata_i, input, WordWidth, combinational read of the buffered partition copy.
REQ-008 SHALL have port digest_i, input, WordWidth, stored partition digest.
REQ-009 SHALL have ports otp_req_o (output, 1), otp_addr_o (output, clog2(NumWords)), otp_gnt_i (input, 1), otp_rvalid_i (input, 1), otp_rdata_i (input, WordWidth), otp_err_i (input, 1); this is the OTP macro read port.
REQ-010 SHALL have port escalate_en_i, input, 1, escalation into the terminal state.
REQ-011 SHALL have outputs busy_o, integ_err_o, cnsty_err_o and fsm_err_o, each 1 bit.

Function
REQ-012 SHALL implement states IdleSt, IntegSt, IntegDoneSt, CnstyReqSt, CnstyWaitSt, CnstyDoneSt and ErrorSt, using a sparse encoding with minimum Hamming distance 3.
REQ-013 In IdleSt, SHALL go to IntegSt if integ_chk_req_i is high, else to CnstyReqSt if cnsty_chk_req_i is high; integrity has priority when both are high; word counter and accumulator clear to 0.
REQ-014 In IntegSt, SHALL drive buf_addr_o = counter each cycle and update acc = rotl(acc,1) ^ buf_rdata_i; after word NumWords-1, SHALL go to IntegDoneSt.
REQ-015 In IntegDoneSt, SHALL pulse integ_chk_ack_o, set sticky integ_err_o if acc != digest_i, and go to IdleSt; ack occurs exactly NumWords+1 cycles after the Idle cycle that sampled the request.
REQ-016 In CnstyReqSt, SHALL assert otp_req_o with otp_addr_o = counter until otp_gnt_i is high, then go to CnstyWaitSt; at most one read is outstanding.
REQ-017 In CnstyWaitSt, on otp_rvalid_i, SHALL compare otp_rdata_i against buf_rdata_i (buf_addr_o = counter).
REQ-018 A mismatch or otp_err_i SHALL set sticky cnsty_err_o.
REQ-019 After otp_rvalid_i, SHALL go to CnstyDoneSt if counter = NumWords-1; otherwise SHALL increment the counter and return to CnstyReqSt.
REQ-020 otp_rvalid_i SHALL be ignored in every state other than CnstyWaitSt.
REQ-021 In CnstyDoneSt, SHALL pulse cnsty_chk_ack_o and go to IdleSt.
REQ-022 A mismatch SHALL NOT suppress the ack; errors are reported only through the sticky flags.
REQ-023 A request still high in the cycle after an ack SHALL be treated as a new request.
REQ-024 busy_o SHALL be high in every state except IdleSt and ErrorSt.
REQ-025 From any state, escalate_en_i high SHALL move the FSM to ErrorSt next cycle; an invalid encoding SHALL do the same and assert fsm_err_o.
REQ-026 In ErrorSt (terminal), SHALL assert fsm_err_o, drive no acks and keep otp_req_o low.
REQ-027 The counter SHALL never wrap: it is bounded at NumWords-1 and cleared only in IdleSt.

Reset
REQ-028 On rst_i, SHALL enter IdleSt and clear the counter and accumulator; all outputs SHALL reset to 0.
REQ-029 rst_i SHALL abort any operation in progress, including one with an outstanding OTP read, without an ack; late rvalids SHALL be ignored.
REQ-030 rst_i SHALL clear the sticky errors and SHALL release ErrorSt.

Configuration
REQ-031 When macro OTP_CTRL_PART_CHK_DIGEST_EN is defined, integrity checks SHALL operate as per REQ-014 and REQ-015.
REQ-032 When OTP_CTRL_PART_CHK_DIGEST_EN is undefined, IntegSt and the accumulator SHALL be omitted: IdleSt goes directly to IntegDoneSt, the ack occurs one cycle after the request is sampled, and integ_err_o is tied 0.

Verification
REQ-033 Bench SHALL cover: words 1..8, digest_i = fold value, integ req at cycle 0 -> integ_chk_ack_o pulse at cycle 9, integ_err_o = 0.
REQ-034 Bench SHALL cover: same as REQ-033 with digest_i bit 0 flipped -> ack at cycle 9, integ_err_o = 1 from cycle 10 until reset.
REQ-035 Bench SHALL cover: cnsty req, otp_gnt_i delayed 3 cycles, otp_rdata_i word 5 = buf ^ 0x1 -> 8 reads in address order, one ack, cnsty_err_o = 1.
REQ-036 Bench SHALL cover: both requests high at cycle 0 -> integrity ack first, consistency run starts the cycle after ack, two acks total.
REQ-037 Bench SHALL cover: rst_i during CnstyWaitSt, word 3 -> no ack, busy_o = 0; a later stray otp_rvalid_i has no effect.
REQ-038 Bench SHALL cover: escalate_en_i mid-IntegSt -> ErrorSt, fsm_err_o = 1, no further acks or otp_req_o until rst_i.

Source files
------------

// File: rtl/otp_ctrl_part_chk_resp.sv
// otp_ctrl_part_chk_resp
//
// Partition check responder. It runs two kinds of check on one OTP partition:
//   - integrity: folds the buffered partition copy into a rotate-xor digest
//     and compares the result with the stored digest_i;
//   - consistency: re-reads every word from the OTP macro and compares each
//     one against the buffered copy.
// Both check kinds report through sticky error flags. The ack pulse always
// fires, even when a check finds a mismatch.
//
// Optional feature macro: OTP_CTRL_PART_CHK_DIGEST_EN
//   defined   -> the integrity check walks all NumWords buffer words through
//                the accumulator (IntegSt).
//   undefined -> IntegSt and the accumulator are not built. An integrity
//                request is acked one cycle after it is sampled, and
//                integ_err_o is tied low.
//
// Handshakes:
//   - integ_chk_req_i and cnsty_chk_req_i are levels. The requester holds a
//     request high until the matching single-cycle ack appears. A request
//     still high in the cycle after its ack counts as a new request.
//   - OTP read port: an address is accepted on a rising clk_i edge where both
//     otp_req_o and otp_gnt_i are high. The data comes back later, on a cycle
//     with otp_rvalid_i high. At most one read is in flight at a time, and
//     otp_rvalid_i is ignored outside CnstyWaitSt.
//
// Debug: fsm_state_o exposes the raw state register.
module otp_ctrl_part_chk_resp #(
    parameter int NumWords  = 8,
    parameter int WordWidth = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        integ_chk_req_i,
    input  logic                        cnsty_chk_req_i,
    output logic                        integ_chk_ack_o,
    output logic                        cnsty_chk_ack_o,
    output logic [$clog2(NumWords)-1:0] buf_addr_o,
    input  logic [WordWidth-1:0]        buf_rdata_i,
    input  logic [WordWidth-1:0]        digest_i,
    output logic                        otp_req_o,
    output logic [$clog2(NumWords)-1:0] otp_addr_o,
    input  logic                        otp_gnt_i,
    input  logic                        otp_rvalid_i,
    input  logic [WordWidth-1:0]        otp_rdata_i,
    input  logic                        otp_err_i,
    input  logic                        escalate_en_i,
    output logic                        busy_o,
    output logic                        integ_err_o,
    output logic                        cnsty_err_o,
    output logic                        fsm_err_o,
    output logic [5:0]                  fsm_state_o
);

    localparam int AddrW = $clog2(NumWords);
    localparam logic [AddrW-1:0] LastAddr = AddrW'(NumWords - 1);

    // Codewords of a [6,3] linear code, so any two states differ in at least
    // 3 bits. IdleSt is all-zero, which makes every output read 0 in reset.
    typedef enum logic [5:0] {
        IdleSt      = 6'b000000,
        IntegSt     = 6'b100110,
        IntegDoneSt = 6'b010101,
        CnstyReqSt  = 6'b001011,
        CnstyWaitSt = 6'b110011,
        CnstyDoneSt = 6'b101101,
        ErrorSt     = 6'b011110
    } state_e;

    state_e           state_q, state_d;
    logic [AddrW-1:0] cnt_q, cnt_d;
    logic             cnsty_err_q, cnsty_err_d;

    logic integ_ack;
    logic cnsty_ack;
    logic otp_req;
    logic busy;
    logic fsm_err;

`ifdef OTP_CTRL_PART_CHK_DIGEST_EN
    logic [WordWidth-1:0] acc_q, acc_d;
    logic                 integ_err_q, integ_err_d;
`else
    // The stored digest has no consumer when the integrity fold is not built.
    logic unused_digest;
    assign unused_digest = ^digest_i;
`endif

    // Next-state logic, datapath updates and per-state outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cnsty_err_d = cnsty_err_q;
`ifdef OTP_CTRL_PART_CHK_DIGEST_EN
        acc_d       = acc_q;
        integ_err_d = integ_err_q;
`endif
        integ_ack   = 1'b0;
        cnsty_ack   = 1'b0;
        otp_req     = 1'b0;
        busy        = 1'b0;
        fsm_err     = 1'b0;

        case (state_q)
            IdleSt: begin
                // Every check starts from word 0 with a clean accumulator.
                cnt_d = '0;
`ifdef OTP_CTRL_PART_CHK_DIGEST_EN
                acc_d = '0;
`endif
                if (integ_chk_req_i) begin
`ifdef OTP_CTRL_PART_CHK_DIGEST_EN
                    state_d = IntegSt;
`else
                    state_d = IntegDoneSt;
`endif
                end else if (cnsty_chk_req_i) begin
                    state_d = CnstyReqSt;
                end
            end

`ifdef OTP_CTRL_PART_CHK_DIGEST_EN
            IntegSt: begin
                busy  = 1'b1;
                acc_d = {acc_q[WordWidth-2:0], acc_q[WordWidth-1]} ^ buf_rdata_i;
                // The counter stops at the last word instead of wrapping.
                if (cnt_q == LastAddr) begin
                    state_d = IntegDoneSt;
                end else begin
                    cnt_d = cnt_q + AddrW'(1);
                end
            end
`endif

            IntegDoneSt: begin
                busy      = 1'b1;
                integ_ack = 1'b1;
`ifdef OTP_CTRL_PART_CHK_DIGEST_EN
                if (acc_q != digest_i) begin
                    integ_err_d = 1'b1;
                end
`endif
                state_d = IdleSt;
            end

            CnstyReqSt: begin
                busy    = 1'b1;
                otp_req = 1'b1;
                if (otp_gnt_i) begin
                    state_d = CnstyWaitSt;
                end
            end

            CnstyWaitSt: begin
                busy = 1'b1;
                if (otp_rvalid_i) begin
                    // A mismatch or a macro error is recorded, and the walk continues.
                    if ((otp_rdata_i != buf_rdata_i) || otp_err_i) begin
                        cnsty_err_d = 1'b1;
                    end
                    if (cnt_q == LastAddr) begin
                        state_d = CnstyDoneSt;
                    end else begin
                        cnt_d   = cnt_q + AddrW'(1);
                        state_d = CnstyReqSt;
                    end
                end
            end

            CnstyDoneSt: begin
                busy      = 1'b1;
                cnsty_ack = 1'b1;
                state_d   = IdleSt;
            end

            ErrorSt: begin
                // Terminal state. Only rst_i leaves it.
                fsm_err = 1'b1;
            end

            default: begin
                // Any other encoding is treated as corruption. This includes
                // IntegSt when the integrity fold is not built.
                fsm_err = 1'b1;
                state_d = ErrorSt;
            end
        endcase

        if (escalate_en_i) begin
            state_d = ErrorSt;
        end
    end

    // State, counter, accumulator and sticky error registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IdleSt;
            cnt_q       <= '0;
            cnsty_err_q <= 1'b0;
`ifdef OTP_CTRL_PART_CHK_DIGEST_EN
            acc_q       <= '0;
            integ_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cnsty_err_q <= cnsty_err_d;
`ifdef OTP_CTRL_PART_CHK_DIGEST_EN
            acc_q       <= acc_d;
            integ_err_q <= integ_err_d;
`endif
        end
    end

    assign integ_chk_ack_o = integ_ack;
    assign cnsty_chk_ack_o = cnsty_ack;
    assign otp_req_o       = otp_req;
    assign busy_o          = busy;
    assign fsm_err_o       = fsm_err;
    assign buf_addr_o      = cnt_q;
    assign otp_addr_o      = cnt_q;
    assign cnsty_err_o     = cnsty_err_q;
    assign fsm_state_o     = state_q;
`ifdef OTP_CTRL_PART_CHK_DIGEST_EN
    assign integ_err_o     = integ_err_q;
`else
    assign integ_err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_otp_ctrl_part_chk_resp.sv
// Bench for otp_ctrl_part_chk_resp.
// A table of check vectors, plus hand-written sequences covering arbitration,
// reset abort and escalation.
`timescale 1ns/1ps
module tb_otp_ctrl_part_chk_resp;

    localparam int NumWords  = 8;
    localparam int WordWidth = 32;
    localparam int AW        = 3;
`ifdef OTP_CTRL_PART_CHK_DIGEST_EN
    localparam bit DigestEn = 1'b1;
`else
    localparam bit DigestEn = 1'b0;
`endif
    localparam int IntegLat = DigestEn ? NumWords + 1 : 1;

    // ---------------- clock / reset / DUT ----------------
    logic clk;
    logic rst_i;
    logic integ_chk_req_i, cnsty_chk_req_i;
    logic integ_chk_ack_o, cnsty_chk_ack_o;
    logic [AW-1:0] buf_addr_o, otp_addr_o;
    logic [WordWidth-1:0] buf_rdata_i, digest_i, otp_rdata_i;
    logic otp_req_o, otp_gnt_i, otp_rvalid_i, otp_err_i, escalate_en_i;
    logic busy_o, integ_err_o, cnsty_err_o, fsm_err_o;
    logic [5:0] fsm_state_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WordWidth-1:0] buf_mem [NumWords];
    assign buf_rdata_i = buf_mem[buf_addr_o];

    otp_ctrl_part_chk_resp #(.NumWords(NumWords), .WordWidth(WordWidth)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .integ_chk_req_i(integ_chk_req_i),
        .cnsty_chk_req_i(cnsty_chk_req_i),
        .integ_chk_ack_o(integ_chk_ack_o),
        .cnsty_chk_ack_o(cnsty_chk_ack_o),
        .buf_addr_o     (buf_addr_o),
        .buf_rdata_i    (buf_rdata_i),
        .digest_i       (digest_i),
        .otp_req_o      (otp_req_o),
        .otp_addr_o     (otp_addr_o),
        .otp_gnt_i      (otp_gnt_i),
        .otp_rvalid_i   (otp_rvalid_i),
        .otp_rdata_i    (otp_rdata_i),
        .otp_err_i      (otp_err_i),
        .escalate_en_i  (escalate_en_i),
        .busy_o         (busy_o),
        .integ_err_o    (integ_err_o),
        .cnsty_err_o    (cnsty_err_o),
        .fsm_err_o      (fsm_err_o),
        .fsm_state_o    (fsm_state_o)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [AW-1:0] exp_addr_q[$];   // expected OTP read addresses, in order
    logic [1:0]    exp_ack_q[$];    // expected acks: {integ, cnsty}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // OTP macro model controls, written by the main sequence only
    int gnt_delay    = 0;
    int rsp_lat      = 1;
    int corrupt_word = -1;
    int err_word     = -1;
    int stray_cnt    = 0;
    int grant_cnt    = 0;   // written by the responder only

    // ---------------- OTP responder (drives on negedge) ----------------
    initial begin : otp_responder
        int gcnt;
        int lcnt;
        int stray_done;
        bit pend;
        logic [AW-1:0] paddr;
        gcnt = 0; lcnt = 0; stray_done = 0; pend = 0; paddr = '0;
        otp_gnt_i = 1'b0; otp_rvalid_i = 1'b0; otp_rdata_i = '0; otp_err_i = 1'b0;
        forever begin
            @(negedge clk);
            otp_gnt_i = 1'b0; otp_rvalid_i = 1'b0; otp_err_i = 1'b0;
            if (rst_i) begin
                pend = 0; gcnt = 0;
            end else if (stray_done != stray_cnt) begin
                stray_done++;
                otp_rvalid_i = 1'b1;
                otp_err_i    = 1'b1;
                otp_rdata_i  = 32'hdead_beef;
            end else if (pend) begin
                chk("one_outstanding", 32'(otp_req_o), 32'd0);
                if (lcnt == 0) begin
                    pend = 0;
                    otp_rvalid_i = 1'b1;
                    otp_rdata_i  = buf_mem[paddr] ^ ((int'(paddr) == corrupt_word) ? 32'h1 : 32'h0);
                    otp_err_i    = (int'(paddr) == err_word);
                end else begin
                    lcnt--;
                end
            end else if (otp_req_o) begin
                if (gcnt >= gnt_delay) begin
                    otp_gnt_i = 1'b1;
                    gcnt = 0; pend = 1; lcnt = rsp_lat; paddr = otp_addr_o;
                    grant_cnt++;
                    if (exp_addr_q.size() == 0) chk("otp_read_unexpected", 32'(otp_addr_o), 32'hffff_ffff);
                    else chk("otp_read_addr", 32'(otp_addr_o), 32'(exp_addr_q.pop_front()));
                end else begin
                    gcnt++;
                end
            end
        end
    end

    // ---------------- ack monitor ----------------
    initial begin : ack_monitor
        forever begin
            @(negedge clk);
            if (integ_chk_ack_o || cnsty_chk_ack_o) begin
                if (exp_ack_q.size() == 0) chk("unexpected_ack", {30'd0, integ_chk_ack_o, cnsty_chk_ack_o}, 32'd0);
                else chk("ack_kind", {30'd0, integ_chk_ack_o, cnsty_chk_ack_o}, 32'(exp_ack_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [31:0] fold_buf();
        logic [31:0] a;
        a = '0;
        for (int i = 0; i < NumWords; i++) a = {a[30:0], a[31]} ^ buf_mem[i];
        return a;
    endfunction

    task automatic fill_buf(input bit rnd);
        for (int i = 0; i < NumWords; i++) buf_mem[i] = rnd ? $urandom() : 32'(i + 1);
    endtask

    task automatic push_reads();
        for (int i = 0; i < NumWords; i++) exp_addr_q.push_back(AW'(i));
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        integ_chk_req_i = 1'b0; cnsty_chk_req_i = 1'b0; escalate_en_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_fsm_err", 32'(fsm_err_o), 32'd0);
        chk("rst_errs", {30'd0, integ_err_o, cnsty_err_o}, 32'd0);
        chk("rst_acks_req", {29'd0, integ_chk_ack_o, cnsty_chk_ack_o, otp_req_o}, 32'd0);
        chk("rst_addrs", {26'd0, buf_addr_o, otp_addr_o}, 32'd0);
        chk("rst_state", 32'(fsm_state_o), 32'd0);
    endtask

    // Waits for an ack of the given kind and drops that request in the ack cycle.
    task automatic wait_ack(input bit integ, input int exp_cyc, input int bound);
        bit seen;
        seen = 0;
        for (int k = 1; k <= bound && !seen; k++) begin
            @(negedge clk);
            if (integ ? integ_chk_ack_o : cnsty_chk_ack_o) begin
                seen = 1;
                if (integ) integ_chk_req_i = 1'b0; else cnsty_chk_req_i = 1'b0;
                if (exp_cyc > 0) chk(integ ? "integ_ack_cycle" : "cnsty_ack_cycle", 32'(k), 32'(exp_cyc));
            end
        end
        if (!seen) chk(integ ? "integ_ack_timeout" : "cnsty_ack_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        bit          integ;
        bit          rnd;
        logic [31:0] flip;
        int          gd;
        int          cw;
        int          ew;
        int          lat;
        bit          exp_err;
    } vec_t;

    // ---------------- main sequence ----------------
    initial begin : main_seq
        vec_t vecs[7];
        int base;
        bit got;
        rst_i = 1'b1; integ_chk_req_i = 1'b0; cnsty_chk_req_i = 1'b0;
        escalate_en_i = 1'b0; digest_i = '0;
        fill_buf(0);

        //        integ rnd flip          gd cw  ew  lat exp_err
        vecs[0] = '{1'b1, 1'b0, 32'h0,         0, -1, -1, 1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'h1,         0, -1, -1, 1, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 32'h0,         3,  5, -1, 1, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 32'h0,         0, -1, -1, 0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 32'h0,         1, -1,  2, 2, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 32'h0,         0, -1, -1, 1, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 32'h8000_0000, 0, -1, -1, 1, 1'b1};

        for (int v = 0; v < 7; v++) begin
            do_reset();
            fill_buf(vecs[v].rnd);
            // Words 1..8 fold to 0x16.
            digest_i = (vecs[v].rnd ? fold_buf() : 32'h16) ^ vecs[v].flip;
            gnt_delay = vecs[v].gd; corrupt_word = vecs[v].cw;
            err_word = vecs[v].ew; rsp_lat = vecs[v].lat;
            if (vecs[v].integ) begin
                exp_ack_q.push_back(2'b10);
                integ_chk_req_i = 1'b1;
                wait_ack(1'b1, IntegLat, IntegLat + 20);
                @(negedge clk);
                chk("integ_err", 32'(integ_err_o), 32'(vecs[v].exp_err & DigestEn));
                repeat (5) @(negedge clk);
                chk("integ_err_sticky", 32'(integ_err_o), 32'(vecs[v].exp_err & DigestEn));
            end else begin
                base = grant_cnt;
                push_reads();
                exp_ack_q.push_back(2'b01);
                cnsty_chk_req_i = 1'b1;
                wait_ack(1'b0, 0, 400);
                chk("cnsty_reads", 32'(grant_cnt - base), 32'(NumWords));
                @(negedge clk);
                chk("cnsty_err", 32'(cnsty_err_o), 32'(vecs[v].exp_err));
                chk("cnsty_busy_after", 32'(busy_o), 32'd0);
            end
        end

        // Both requests at once: integrity goes first, and consistency is
        // sampled in the cycle after the integrity ack.
        do_reset();
        fill_buf(0); digest_i = 32'h16;
        gnt_delay = 0; rsp_lat = 1; corrupt_word = -1; err_word = -1;
        exp_ack_q.push_back(2'b10); exp_ack_q.push_back(2'b01);
        push_reads();
        integ_chk_req_i = 1'b1; cnsty_chk_req_i = 1'b1;
        wait_ack(1'b1, IntegLat, IntegLat + 20);
        @(negedge clk);
        chk("both_idle_after_ack", {30'd0, busy_o, otp_req_o}, 32'd0);
        @(negedge clk);
        chk("both_cnsty_started", {30'd0, busy_o, otp_req_o}, 32'd3);
        wait_ack(1'b0, 0, 400);
        @(negedge clk);
        chk("both_errs", {30'd0, integ_err_o, cnsty_err_o}, 32'd0);

        // Reset while the read of word 3 is outstanding, followed by a stray rvalid.
        do_reset();
        fill_buf(1);
        gnt_delay = 0; rsp_lat = 5;
        push_reads();
        base = grant_cnt;
        cnsty_chk_req_i = 1'b1;
        got = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (grant_cnt - base == 4) got = 1;
        end
        chk("abort_reached_word3", 32'(got), 32'd1);
        @(negedge clk);
        chk("abort_wait_busy", {30'd0, busy_o, otp_req_o}, 32'd2);
        do_reset();
        exp_addr_q.delete();
        stray_cnt++;
        repeat (4) @(negedge clk);
        chk("abort_after_stray", {29'd0, busy_o, otp_req_o, cnsty_err_o}, 32'd0);
        chk("abort_state_idle", 32'(fsm_state_o), 32'd0);

        // Escalation in the middle of a check.
        do_reset();
        fill_buf(0); digest_i = 32'h16; rsp_lat = 1;
        push_reads();
`ifdef OTP_CTRL_PART_CHK_DIGEST_EN
        integ_chk_req_i = 1'b1;
`else
        cnsty_chk_req_i = 1'b1;
`endif
        repeat (4) @(negedge clk);
        escalate_en_i = 1'b1;
        @(negedge clk);
        escalate_en_i = 1'b0;
        for (int k = 0; k < 15; k++) begin
            chk("esc_fsm_err", 32'(fsm_err_o), 32'd1);
            chk("esc_quiet", {30'd0, busy_o, otp_req_o}, 32'd0);
            @(negedge clk);
        end
        do_reset();
        exp_addr_q.delete();
        repeat (3) @(negedge clk);
        chk("esc_released", 32'(fsm_err_o), 32'd0);

        chk("ack_queue_drained", 32'(exp_ack_q.size()), 32'd0);
        chk("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
